// File: rtl/page_xfer_ctrl.sv
// rtl/page_xfer_ctrl.sv - NAND page column transfer sequencer (optional stall timeout: PAGE_XFER_TIMEOUT_EN)
module page_xfer_ctrl #(
  parameter int ADDR_BITS      = 12,
  parameter int MAX_LEN        = 2112,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk2,
  input  logic                 NReset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_len,
  input  logic                 abort,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 ACC_Enable,
  output logic                 ACC_Clear,
  output logic [ADDR_BITS-1:0] End_address,
  input  logic                 ADDReached,
  output logic                 busy,
  output logic                 xfer_done,
  output logic                 len_error,
  output logic                 aborted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  localparam logic [ADDR_BITS-1:0] MAX_LEN_W = ADDR_BITS'(MAX_LEN);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   end_addr_q, end_addr_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   acc_clear_q, acc_clear_d;
  logic                   xfer_done_q, xfer_done_d;
  logic                   len_error_q, len_error_d;
  logic                   aborted_q, aborted_d;
  logic                   cmd_len_ok;
  logic                   acc_enable;
  logic                   stall_hit;

  // A byte is never taken once the end address is reached or while an abort is pending.
  assign byte_ready = (state_q == S_XFER) & ~ADDReached & ~abort;
  assign acc_enable = byte_valid & byte_ready;
  assign cmd_len_ok = (cmd_len != '0) && (cmd_len <= MAX_LEN_W);

`ifdef PAGE_XFER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [STALL_W-1:0] stall_q, stall_d;

  // Count consecutive XFER cycles without an accepted byte; zero outside XFER so entry starts fresh.
  always_comb begin
    stall_d   = '0;
    stall_hit = 1'b0;
    if (state_q == S_XFER && !acc_enable) begin
      stall_d   = stall_q + 1'b1;
      stall_hit = (stall_d == STALL_W'(TIMEOUT_CYCLES));
    end
  end

  // Stall counter register.
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_timeout_cfg;

  // Without the stall counter XFER waits indefinitely and TIMEOUT_CYCLES has no effect.
  assign stall_hit          = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next state plus output decode of the next state, so all status outputs come straight from flops.
  always_comb begin
    state_d     = state_q;
    end_addr_d  = end_addr_q;
    len_error_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len_ok) begin
            state_d    = S_SETUP;
            end_addr_d = cmd_len;
          end else begin
            len_error_d = 1'b1;
          end
        end
      end
      S_SETUP: state_d = abort ? S_ABORT : S_XFER;
      S_XFER: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (ADDReached) begin
          state_d = S_DONE;
        end else if (stall_hit) begin
          state_d = S_ABORT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    acc_clear_d = (state_d == S_SETUP) || (state_d == S_ABORT);
    xfer_done_d = (state_d == S_DONE);
    aborted_d   = (state_d == S_ABORT);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state_q     <= S_IDLE;
      end_addr_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      acc_clear_q <= 1'b0;
      xfer_done_q <= 1'b0;
      len_error_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      end_addr_q  <= end_addr_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      acc_clear_q <= acc_clear_d;
      xfer_done_q <= xfer_done_d;
      len_error_q <= len_error_d;
      aborted_q   <= aborted_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign ACC_Clear   = acc_clear_q;
  assign ACC_Enable  = acc_enable;
  assign End_address = end_addr_q;
  assign xfer_done   = xfer_done_q;
  assign len_error   = len_error_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_page_xfer_ctrl.sv
// tb/tb_page_xfer_ctrl.sv - directed self-checking bench for page_xfer_ctrl
module tb_page_xfer_ctrl;

  logic        clk2 = 1'b0;
  logic        NReset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_len;
  logic        abort;
  logic        byte_valid;
  logic        byte_ready;
  logic        ACC_Enable;
  logic        ACC_Clear;
  logic [11:0] End_address;
  logic        ADDReached;
  logic        busy;
  logic        xfer_done;
  logic        len_error;
  logic        aborted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int en_cnt, clr_cnt, done_cnt, abt_cnt, lerr_cnt;
  int clr_cyc, done_cyc, abt_cyc, rdy_cyc;
  logic busy_seen;
  logic prev_rdy = 1'b1;
  logic [11:0] col_cnt;

  page_xfer_ctrl #(
    .ADDR_BITS      (12),
    .MAX_LEN        (2112),
    .TIMEOUT_CYCLES (256)
  ) dut (
    .clk2        (clk2),
    .NReset      (NReset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .abort       (abort),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .ACC_Enable  (ACC_Enable),
    .ACC_Clear   (ACC_Clear),
    .End_address (End_address),
    .ADDReached  (ADDReached),
    .busy        (busy),
    .xfer_done   (xfer_done),
    .len_error   (len_error),
    .aborted     (aborted)
  );

  always #5 clk2 = ~clk2;

  always @(posedge clk2) cyc <= cyc + 1;

  // External 12-bit column counter: clear, count enable, rollover flag at End_address.
  always @(posedge clk2 or negedge NReset) begin
    if (!NReset) col_cnt <= '0;
    else if (ACC_Clear) col_cnt <= '0;
    else if (ACC_Enable) col_cnt <= col_cnt + 12'd1;
  end
  assign ADDReached = (col_cnt == End_address);

  // Pulse monitor, sampled mid-cycle after inputs have settled.
  always @(negedge clk2) begin
    #2;
    if (ACC_Enable) en_cnt++;
    if (ACC_Clear) begin clr_cnt++; clr_cyc = cyc; end
    if (xfer_done) begin done_cnt++; done_cyc = cyc; end
    if (aborted) begin abt_cnt++; abt_cyc = cyc; end
    if (len_error) lerr_cnt++;
    if (busy) busy_seen = 1'b1;
    if (cmd_ready && !prev_rdy) rdy_cyc = cyc;
    prev_rdy = cmd_ready;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0; clr_cnt = 0; done_cnt = 0; abt_cnt = 0; lerr_cnt = 0;
    clr_cyc = -1; done_cyc = -1; abt_cyc = -1; rdy_cyc = -1;
    busy_seen = 1'b0;
  endtask

  // Full-rate transfer of len bytes with byte_valid held high.
  task automatic run_xfer(input int len, input string tag);
    int t0;
    @(negedge clk2);
    clear_stats();
    t0 = cyc;
    cmd_valid = 1'b1; cmd_len = 12'(len); byte_valid = 1'b1;
    #1 check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    @(negedge clk2);
    cmd_valid = 1'b0;
    repeat (len + 6) @(negedge clk2);
    byte_valid = 1'b0;
    check({tag, "_enables"}, en_cnt, len);
    check({tag, "_clear_cyc"}, clr_cyc - t0, 1);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc - t0, len + 3);
    check({tag, "_ready_cyc"}, rdy_cyc - t0, len + 4);
    check({tag, "_end_addr"}, int'(End_address), len);
  endtask

  initial begin
    int t0;
    NReset = 1'b0; cmd_valid = 1'b0; cmd_len = '0; abort = 1'b0; byte_valid = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk2);
    #1;
    check("rst_end_addr", int'(End_address), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clear", int'(ACC_Clear), 0);
    check("rst_pulses", int'({xfer_done, len_error, aborted}), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_byte_ready", int'(byte_ready), 0);
    @(negedge clk2);
    NReset = 1'b1;

    // Basic 4-byte transfer: clear at T+1, done at T+7.
    run_xfer(4, "len4");

    // Illegal lengths 0 and 2113, back to back.
    @(negedge clk2);
    clear_stats();
    cmd_valid = 1'b1; cmd_len = 12'd0;
    @(negedge clk2);
    cmd_len = 12'd2113;
    #1 check("len0_error_pulse", int'(len_error), 1);
    @(negedge clk2);
    cmd_valid = 1'b0;
    #1 check("len2113_error_pulse", int'(len_error), 1);
    repeat (4) @(negedge clk2);
    check("bad_len_errors", lerr_cnt, 2);
    check("bad_len_no_clear", clr_cnt, 0);
    check("bad_len_not_busy", int'(busy_seen), 0);
    check("bad_len_end_addr", int'(End_address), 4);

    // Minimum legal length.
    run_xfer(1, "len1");

    // Maximum length with random byte_valid.
    @(negedge clk2);
    clear_stats();
    cmd_valid = 1'b1; cmd_len = 12'd2112;
    for (int i = 0; i < 9000 && done_cnt == 0; i++) begin
      @(negedge clk2);
      cmd_valid = 1'b0;
      byte_valid = 1'($urandom_range(0, 1));
    end
    byte_valid = 1'b0;
    repeat (3) @(negedge clk2);
    check("max_done_cnt", done_cnt, 1);
    check("max_enables", en_cnt, 2112);
    check("max_end_addr", int'(End_address), 32'h840);
    check("max_no_abort", abt_cnt, 0);

    // Abort after 5 bytes of a 16-byte transfer.
    @(negedge clk2);
    clear_stats();
    t0 = cyc;
    cmd_valid = 1'b1; cmd_len = 12'd16; byte_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk2);
      cmd_valid = 1'b0;
    end
    @(negedge clk2);
    abort = 1'b1;
    #1 check("abort_byte_refused", int'(byte_ready), 0);
    @(negedge clk2);
    abort = 1'b0;
    #1;
    check("abort_clear", int'(ACC_Clear), 1);
    check("abort_pulse", int'(aborted), 1);
    @(negedge clk2);
    byte_valid = 1'b0;
    #1;
    check("abort_idle_ready", int'(cmd_ready), 1);
    check("abort_idle_busy", int'(busy), 0);
    check("abort_enables", en_cnt, 5);
    check("abort_cyc", abt_cyc - t0, 8);
    check("abort_no_done", done_cnt, 0);
    check("abort_clears", clr_cnt, 2);
    repeat (3) @(negedge clk2);
    check("abort_single_pulse", abt_cnt, 1);

    // Abort while idle is ignored.
    @(negedge clk2);
    clear_stats();
    abort = 1'b1;
    @(negedge clk2);
    abort = 1'b0;
    repeat (2) @(negedge clk2);
    check("idle_abort_ignored", abt_cnt + clr_cnt, 0);

    // Reset in the middle of a transfer, then a clean 3-byte transfer.
    @(negedge clk2);
    cmd_valid = 1'b1; cmd_len = 12'd10; byte_valid = 1'b1;
    @(negedge clk2);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk2);
    NReset = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_byte_ready", int'(byte_ready), 0);
    check("mid_rst_end_addr", int'(End_address), 0);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk2);
    NReset = 1'b1; byte_valid = 1'b0;
    run_xfer(3, "post_rst_len3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
